// File: rtl/debug_link_pkg.sv
// Shared definitions for both ends of the UART debug link: command codes,
// host FSM state encoding and the response frame length.
package debug_link_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STEP = 8'h03;

    // 2558 pipeline bits rounded up to whole bytes; the board-side FSM uses the same value.
    localparam int DEFAULT_FRAME_BYTES = 320;

    localparam logic [2:0] ENC_IDLE      = 3'd0;
    localparam logic [2:0] ENC_SEND_CMD  = 3'd1;
    localparam logic [2:0] ENC_WAIT_CMD  = 3'd2;
    localparam logic [2:0] ENC_SEND_WORD = 3'd3;
    localparam logic [2:0] ENC_WAIT_WORD = 3'd4;
    localparam logic [2:0] ENC_RECV      = 3'd5;
    localparam logic [2:0] ENC_ERROR     = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE      = ENC_IDLE,
        ST_SEND_CMD  = ENC_SEND_CMD,
        ST_WAIT_CMD  = ENC_WAIT_CMD,
        ST_SEND_WORD = ENC_SEND_WORD,
        ST_WAIT_WORD = ENC_WAIT_WORD,
        ST_RECV      = ENC_RECV,
        ST_ERROR     = ENC_ERROR
    } state_t;

    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return (cmd == CMD_LOAD) || (cmd == CMD_RUN) || (cmd == CMD_STEP);
    endfunction

    // Program words go out MSB first: sel 0 is bits [31:24].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] sel);
        logic [7:0] b;
        case (sel)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/debug_frame_buffer.sv
// Response frame store: one write port, one registered read port.
// A read of the address being written returns the new byte.
module debug_frame_buffer #(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [7:0]        i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [7:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= 8'h00;
        end else if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/debug_host_link.sv
// Host side of the UART debug protocol: sends a command, optionally streams
// program words, then captures the fixed-length pipeline dump into a buffer.
module debug_host_link
    import debug_link_pkg::*;
#(
    parameter int FRAME_BYTES    = DEFAULT_FRAME_BYTES,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int ADDR_W         = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [7:0]        i_cmd,
    input  logic [7:0]        i_word_count,
    input  logic [31:0]       i_instr,
    output logic [7:0]        o_instr_idx,
    output logic [7:0]        o_tx_data,
    output logic              os_tx_start,
    input  logic              is_tx_done,
    input  logic [7:0]        i_rx_data,
    input  logic              is_rx_done,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_valid,
    output logic              o_error
);

    localparam int                TMR_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_W-1:0] WPTR_LAST = ADDR_W'(FRAME_BYTES - 1);

    state_t            r_state, w_state_next;
    logic [7:0]        r_cmd, w_cmd_next;
    logic [7:0]        r_count, w_count_next;
    logic [7:0]        r_idx, w_idx_next;
    logic [1:0]        r_byte, w_byte_next;
    logic [31:0]       r_shadow, w_shadow_next;
    logic [ADDR_W-1:0] r_wptr, w_wptr_next;
    logic [TMR_W-1:0]  r_timer, w_timer_next;
    logic [7:0]        r_tx_data, w_tx_data_next;
    logic              r_tx_start, w_tx_start_next;
    logic              r_done, w_done_next;
    logic              r_frame_valid, w_frame_valid_next;
    logic              r_error, w_error_next;

    logic w_buf_we;
    logic w_timing;
    logic w_expired;

    assign w_buf_we  = (r_state == ST_RECV) && is_rx_done;
    assign w_timing  = (r_state == ST_WAIT_CMD) || (r_state == ST_WAIT_WORD) || (r_state == ST_RECV);
    assign w_expired = (r_timer == TMR_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_cmd         <= 8'h00;
            r_count       <= 8'h00;
            r_idx         <= 8'h00;
            r_byte        <= 2'd0;
            r_shadow      <= 32'h0;
            r_wptr        <= '0;
            r_timer       <= '0;
            r_tx_data     <= 8'h00;
            r_tx_start    <= 1'b0;
            r_done        <= 1'b0;
            r_frame_valid <= 1'b0;
            r_error       <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cmd         <= w_cmd_next;
            r_count       <= w_count_next;
            r_idx         <= w_idx_next;
            r_byte        <= w_byte_next;
            r_shadow      <= w_shadow_next;
            r_wptr        <= w_wptr_next;
            r_timer       <= w_timer_next;
            r_tx_data     <= w_tx_data_next;
            r_tx_start    <= w_tx_start_next;
            r_done        <= w_done_next;
            r_frame_valid <= w_frame_valid_next;
            r_error       <= w_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_cmd_next         = r_cmd;
        w_count_next       = r_count;
        w_idx_next         = r_idx;
        w_byte_next        = r_byte;
        w_shadow_next      = r_shadow;
        w_wptr_next        = r_wptr;
        w_tx_data_next     = r_tx_data;
        w_tx_start_next    = 1'b0;
        w_done_next        = 1'b0;
        w_frame_valid_next = r_frame_valid;
        w_error_next       = r_error;
        w_timer_next       = '0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (is_valid_cmd(i_cmd)) begin
                        w_cmd_next         = i_cmd;
                        w_count_next       = i_word_count;
                        w_idx_next         = 8'h00;
                        w_byte_next        = 2'd0;
                        w_wptr_next        = '0;
                        w_frame_valid_next = 1'b0;
                        w_error_next       = 1'b0;
                        w_state_next       = ST_SEND_CMD;
                    end else begin
                        w_error_next = 1'b1;
                    end
                end
            end
            ST_SEND_CMD: begin
                w_tx_data_next  = r_cmd;
                w_tx_start_next = 1'b1;
                w_state_next    = ST_WAIT_CMD;
            end
            ST_WAIT_CMD: begin
                if (is_tx_done) begin
                    if (r_cmd != CMD_LOAD) begin
                        w_wptr_next  = '0;
                        w_state_next = ST_RECV;
                    end else if (r_count != 8'h00) begin
                        w_idx_next   = 8'h00;
                        w_byte_next  = 2'd0;
                        w_state_next = ST_SEND_WORD;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_ERROR;
                end
            end
            ST_SEND_WORD: begin
                // The source word is only guaranteed stable while its index is
                // presented, so capture it once and send the later bytes from the copy.
                if (r_byte == 2'd0) begin
                    w_shadow_next  = i_instr;
                    w_tx_data_next = word_byte(i_instr, 2'd0);
                end else begin
                    w_tx_data_next = word_byte(r_shadow, r_byte);
                end
                w_tx_start_next = 1'b1;
                w_state_next    = ST_WAIT_WORD;
            end
            ST_WAIT_WORD: begin
                if (is_tx_done) begin
                    if (r_byte != 2'd3) begin
                        w_byte_next  = r_byte + 2'd1;
                        w_state_next = ST_SEND_WORD;
                    end else if (r_idx != (r_count - 8'd1)) begin
                        w_idx_next   = r_idx + 8'd1;
                        w_byte_next  = 2'd0;
                        w_state_next = ST_SEND_WORD;
                    end else begin
                        w_done_next  = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_ERROR;
                end
            end
            ST_RECV: begin
                // An arriving byte takes priority over an expiring timer.
                if (is_rx_done) begin
                    w_wptr_next = r_wptr + 1'b1;
                    if (r_wptr == WPTR_LAST) begin
                        w_frame_valid_next = 1'b1;
                        w_done_next        = 1'b1;
                        w_state_next       = ST_IDLE;
                    end
                end else if (w_expired) begin
                    w_error_next = 1'b1;
                    w_state_next = ST_ERROR;
                end
            end
            ST_ERROR: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if ((w_state_next != r_state) || is_tx_done || is_rx_done) begin
            w_timer_next = '0;
        end else if (w_timing) begin
            w_timer_next = r_timer + 1'b1;
        end
    end

    debug_frame_buffer #(
        .DEPTH  (FRAME_BYTES),
        .ADDR_W (ADDR_W)
    ) u_frame_buffer (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_buf_we),
        .i_waddr (r_wptr),
        .i_wdata (i_rx_data),
        .i_raddr (i_rd_addr),
        .o_rdata (o_rd_data)
    );

    assign o_instr_idx   = r_idx;
    assign o_tx_data     = r_tx_data;
    assign os_tx_start   = r_tx_start;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = r_done;
    assign o_frame_valid = r_frame_valid;
    assign o_error       = r_error;

endmodule

// File: doc/debug_host_link.md
Name: debug_host_link

Overview:
- Host-side counterpart of the board's debug unit: drives the command/program side of the UART debug protocol and collects the pipeline-state dump it returns.
- Sits between the existing Tx/Rx/BaudRate UART byte cores and a local controller (board-to-board loopback rig, or self-check harness).
- Sends a command byte, optionally streams program words (address implied by order), then captures the fixed-length response frame into a byte buffer readable by the controller.

Parameters:
- FRAME_BYTES, 320, bytes per response frame (2558 pipeline bits rounded up to whole bytes).
- TIMEOUT_CYCLES, 2000000, max clk cycles allowed between protocol events before abort.
- ADDR_W, 9, buffer read-address width; must satisfy 2**ADDR_W >= FRAME_BYTES.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle request; sampled only in IDLE.
- i_cmd  in  8  command: 8'h01 LOAD, 8'h02 RUN, 8'h03 STEP.
- i_word_count  in  8  LOAD only: number of 32-bit words, 0..255.
- i_instr  in  32  current program word; combinational from source, indexed by o_instr_idx.
- o_instr_idx  out  8  index of word being sent.
- o_tx_data  out  8  byte to UART Tx.
- os_tx_start  out  1  one-cycle Tx start pulse.
- is_tx_done  in  1  Tx byte-complete pulse.
- i_rx_data  in  8  byte from UART Rx.
- is_rx_done  in  1  Rx byte-valid pulse.
- i_rd_addr  in  ADDR_W  frame buffer read address.
- o_rd_data  out  8  buffer byte, registered, 1-cycle read latency.
- o_busy  out  1  high whenever state != IDLE.
- o_done  out  1  one-cycle pulse on successful completion.
- o_frame_valid  out  1  buffer holds a complete frame; cleared on next accepted i_start.
- o_error  out  1  sticky; cleared on next accepted i_start.

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; counters, indices and pointers 0. Buffer contents undefined.
- States: IDLE, SEND_CMD, WAIT_CMD, SEND_WORD, WAIT_WORD, RECV, ERROR.
- IDLE:
  - i_start with a valid cmd: latch cmd and count, clear o_frame_valid/o_error, go to SEND_CMD.
  - i_start with an invalid cmd: set o_error, stay IDLE, transmit nothing.
  - i_start while busy: ignored.
- SEND_CMD: drive o_tx_data=cmd, pulse os_tx_start for exactly 1 cycle, go to WAIT_CMD.
- WAIT_CMD: on is_tx_done:
  - LOAD with count>0: go to SEND_WORD, idx=0, byte=0.
  - LOAD with count=0: pulse o_done, go to IDLE.
  - RUN/STEP: go to RECV, wptr=0.
- SEND_WORD:
  - Byte 0 latches i_instr into a shadow register.
  - Bytes are sent MSB first: [31:24],[23:16],[15:8],[7:0].
  - One os_tx_start pulse per byte, then go to WAIT_WORD.
- WAIT_WORD: on is_tx_done:
  - byte<3: byte+1, back to SEND_WORD.
  - byte=3 and idx<count-1: idx+1, byte=0, back to SEND_WORD.
  - Otherwise: pulse o_done, go to IDLE.
- os_tx_start is never asserted before the previous byte's is_tx_done.
- RECV:
  - Each is_rx_done writes i_rx_data to buffer[wptr], then wptr+1.
  - On the write of byte FRAME_BYTES-1: set o_frame_valid, pulse o_done, go to IDLE (same cycle as that write).
- Rx bytes outside RECV are discarded; they do not touch the buffer.
- is_tx_done outside WAIT_* is ignored.
- Timeout:
  - Counter clears on every state entry and on every is_rx_done/is_tx_done.
  - Runs in WAIT_CMD, WAIT_WORD and RECV.
  - Reaching TIMEOUT_CYCLES-1 goes to ERROR: o_error=1, o_frame_valid stays 0; next cycle go to IDLE.
  - The partial frame stays readable.
- Simultaneous is_rx_done and timeout expiry in the same cycle: the byte wins; counter clears, no error.
- rst asserted mid-transfer: immediate return to reset state; no os_tx_start glitch.
- Read port is always active and independent of state, including during RECV (returns old/new data per write-first RAM).

Decomposition:
- Package debug_link_pkg:
  - command codes CMD_LOAD/CMD_RUN/CMD_STEP;
  - state encoding localparams;
  - FRAME_BYTES default (shared with the board-side FSM so both ends agree on frame length).
- Sub-module debug_frame_buffer: simple dual-port RAM (1 write port, 1 registered read port), FRAME_BYTES x 8.

Test Plan:
- LOAD, count=2, words 32'h8C010004, 32'hFFFFFFFF; Tx model returns is_tx_done 10 cycles after each start -> byte sequence 01,8C,01,00,04,FF,FF,FF,FF; exactly 9 os_tx_start pulses; o_done once; o_busy low afterwards.
- STEP; Rx model sends bytes 0..319 mod 256 -> o_frame_valid=1, o_done once; reading addr 0,255,319 gives 00,FF,3F with 1-cycle latency.
- RUN; Rx stops after 100 bytes, TIMEOUT_CYCLES=50 in the bench -> o_error=1 about 50 cycles after the last byte; o_frame_valid=0; buffer[99] holds byte 99; next valid i_start clears o_error.
- i_cmd=8'h07 -> o_error=1, no os_tx_start, state stays IDLE; Rx bytes injected in IDLE are not written to the buffer.
- Assert rst during SEND_WORD byte 2 -> all outputs 0 within the same cycle; a fresh LOAD after release transmits from the command byte.
- LOAD count=0 -> only the command byte is sent, then o_done; i_start pulsed during busy is ignored (no second command byte).
